// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a single-cycle issue path and a counted MULT/DIV occupancy window.
// Define ALU_CTRL_SEQ_DIV_EN to decode funct 011010 as a multi-cycle DIV; otherwise it is illegal.
module alu_ctrl_seq #(
  parameter int CTRL_W   = 4,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] ctrl,
  output logic              out_valid,
  output logic              busy,
  output logic              illegal
);

`ifdef ALU_CTRL_SEQ_DIV_EN
  localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
`else
  localparam int LAT_MAX = MULT_LAT;
`endif
  localparam int CNT_W = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;

  if (CTRL_W < 4 || MULT_LAT < 2 || DIV_LAT < 2) begin : g_param_check
    $error("alu_ctrl_seq: CTRL_W must be >= 4 and latencies >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  typedef struct packed {
    logic       multi;
    logic       bad;
    logic [3:0] code;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] op, input logic [5:0] f);
    dec_t d;
    d = '0;
    case (op)
      2'b01: d.code = 4'b0011;
      2'b10: d.code = 4'b0100;
      2'b11: d.code = 4'b0001;
      default: begin
        case (f)
          6'b100000: d.code = 4'b0011;
          6'b100010: d.code = 4'b0100;
          6'b100100: d.code = 4'b0000;
          6'b100101: d.code = 4'b0001;
          6'b101010: d.code = 4'b0101;
          6'b000000: d.code = 4'b1001;
          6'b000010: d.code = 4'b1100;
          6'b011000: begin
            d.code  = 4'b0110;
            d.multi = 1'b1;
          end
`ifdef ALU_CTRL_SEQ_DIV_EN
          6'b011010: begin
            d.code  = 4'b0111;
            d.multi = 1'b1;
          end
`endif
          default: d.bad = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

  state_t           state;
  logic [CTRL_W-1:0] ctrl_r;
  logic [CNT_W-1:0] cnt;
  dec_t             dec;
  logic [CNT_W-1:0] lat_load;

  always_comb begin
    dec = decode(alu_op, funct);
`ifdef ALU_CTRL_SEQ_DIV_EN
    lat_load = (funct == 6'b011010) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
`else
    lat_load = CNT_W'(MULT_LAT - 1);
`endif
  end

  // Acceptance depends only on state so in_valid never loops back into in_ready.
  assign in_ready = (state != S_BUSY);
  assign ctrl     = ctrl_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ctrl_r    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        S_IDLE, S_ISSUE: begin
          if (in_valid) begin
            ctrl_r <= CTRL_W'(dec.code);
            if (dec.multi) begin
              state <= S_BUSY;
              busy  <= 1'b1;
              cnt   <= lat_load;
            end else begin
              state     <= S_ISSUE;
              out_valid <= 1'b1;
              illegal   <= dec.bad;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          // cnt counts the busy cycles still to come; result is flagged in the last one.
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) out_valid <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus randomized traffic against a cycle-count model.
module tb_alu_ctrl_seq;
  localparam int CTRL_W   = 4;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 8;
`ifdef ALU_CTRL_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [1:0]        alu_op = 2'b00;
  logic [5:0]        funct = 6'b000000;
  logic              in_ready;
  logic [CTRL_W-1:0] ctrl;
  logic              out_valid;
  logic              busy;
  logic              illegal;

  alu_ctrl_seq #(.CTRL_W(CTRL_W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .ctrl(ctrl), .out_valid(out_valid),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: number of busy cycles still ahead, plus the expected output registers.
  int         bl = 0;
  logic [3:0] m_ctrl = 4'b0;
  logic       m_ov = 1'b0;
  logic       m_ill = 1'b0;

  logic [5:0] ftab [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                           6'b000000, 6'b000010, 6'b011000, 6'b011010};
  logic [3:0] ctab [9] = '{4'b0011, 4'b0100, 4'b0000, 4'b0001, 4'b0101,
                           4'b1001, 4'b1100, 4'b0110, 4'b0111};
  int         ltab [9] = '{0, 0, 0, 0, 0, 0, 0, MULT_LAT, DIV_LAT};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic model_decode(input logic [1:0] op, input logic [5:0] f,
                              output logic [3:0] code, output logic bd, output int lat);
    code = 4'b0000; bd = 1'b0; lat = 0;
    if (op == 2'b01) code = 4'b0011;
    else if (op == 2'b10) code = 4'b0100;
    else if (op == 2'b11) code = 4'b0001;
    else begin
      bd = 1'b1;
      for (int i = 0; i < 9; i++)
        if (ftab[i] == f) begin code = ctab[i]; lat = ltab[i]; bd = 1'b0; end
      if (!DIV_EN && f == 6'b011010) begin code = 4'b0000; lat = 0; bd = 1'b1; end
    end
  endtask

  task automatic model_reset();
    bl = 0; m_ctrl = 4'b0; m_ov = 1'b0; m_ill = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
    in_valid = v; alu_op = op; funct = f;
  endtask

  // One clock: advance the model on the edge, then compare every output just after it.
  task automatic step();
    logic [3:0] c;
    logic       b;
    int         lat;
    bit         ready;
    @(posedge clk);
    ready = (bl == 0);
    m_ov = 1'b0; m_ill = 1'b0;
    if (bl > 0) bl--;
    if (ready && in_valid) begin
      model_decode(alu_op, funct, c, b, lat);
      m_ctrl = c;
      if (lat > 0) bl = lat;
      else begin m_ov = 1'b1; m_ill = b; end
    end
    if (bl == 1) m_ov = 1'b1;
    #1;
    chk("ctrl", 32'(ctrl), 32'(m_ctrl));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("busy", 32'(busy), 32'(bl > 0));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("in_ready", 32'(in_ready), 32'(bl == 0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 32'(ctrl), 32'd0);
    chk({tag, "_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ill"}, 32'(illegal), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    drive(1'b0, 2'b00, 6'b0);
    while (bl > 0 && n < 20) begin step(); n++; end
    if (bl > 0) chk({tag, "_drain_timeout"}, 32'(bl), 32'd0);
  endtask

  initial begin
    #2;
    chk_reset_outputs("rst_async");
    #10 rst_n = 1'b1;

    // Single-cycle R-type SUB.
    drive(1'b1, 2'b00, 6'b100010); step();
    chk("sub_ctrl", 32'(ctrl), 32'h4);
    chk("sub_ov", 32'(out_valid), 32'd1);
    chk("sub_busy", 32'(busy), 32'd0);
    drive(1'b0, 2'b00, 6'b0); step();
    chk("sub_ov_drop", 32'(out_valid), 32'd0);
    chk("sub_ctrl_hold", 32'(ctrl), 32'h4);

    // Four back-to-back accepts.
    drive(1'b1, 2'b01, 6'b0); step();
    chk("b2b0", 32'({ctrl, out_valid}), 32'h7);
    drive(1'b1, 2'b10, 6'b0); step();
    chk("b2b1", 32'({ctrl, out_valid}), 32'h9);
    drive(1'b1, 2'b11, 6'b0); step();
    chk("b2b2", 32'({ctrl, out_valid}), 32'h3);
    drive(1'b1, 2'b00, 6'b101010); step();
    chk("b2b3", 32'({ctrl, out_valid}), 32'hb);

    // MULT occupancy, with a pending ADD held on the inputs.
    drive(1'b1, 2'b00, 6'b011000); step();
    chk("mul_busy1", 32'({busy, in_ready, out_valid}), 32'h4);
    chk("mul_ctrl", 32'(ctrl), 32'h6);
    drive(1'b1, 2'b00, 6'b100000);
    step(); chk("mul_c2", 32'({busy, out_valid}), 32'h2);
    step(); chk("mul_c3", 32'({busy, out_valid}), 32'h2);
    step(); chk("mul_c4", 32'({busy, out_valid, ctrl}), 32'h36);
    step(); chk("mul_idle", 32'({busy, in_ready, out_valid}), 32'h2);
    step(); chk("mul_next", 32'({ctrl, out_valid}), 32'h7);

    // Illegal funct and the configurable DIV code.
    drive(1'b1, 2'b00, 6'b111111); step();
    chk("ill_resp", 32'({ctrl, illegal, out_valid}), 32'h3);
    drive(1'b1, 2'b00, 6'b011010); step();
    if (DIV_EN) chk("div_start", 32'({ctrl, busy, illegal}), 32'h1e);
    else        chk("div_ill", 32'({ctrl, illegal, out_valid, busy}), 32'h6);
    drain("div");
    step();

    // Reset in the middle of a long operation.
    drive(1'b1, 2'b00, DIV_EN ? 6'b011010 : 6'b011000); step();
    drive(1'b0, 2'b00, 6'b0);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_busy");
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_no_ov", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] op;
      logic [5:0] f;
      op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ftab[$urandom_range(0, 8)];
      drive(($urandom_range(0, 3) != 0), op, f);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rnd_rst");
        model_reset();
        #1 rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, control-word width (>=4; codes zero-extended above bit 3).
REQ-002 SHALL have parameter MULT_LAT, default 4, multiply occupancy in cycles (>=2).
REQ-003 SHALL have parameter DIV_LAT, default 8, divide occupancy in cycles (>=2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  decode request present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 alu_op  input  2  main-decoder op class.
REQ-009 funct  input  6  R-type function field.
REQ-010 ctrl  output  CTRL_W  registered ALU control word.
REQ-011 out_valid  output  1  ctrl is final for the accepted request.
REQ-012 busy  output  1  multi-cycle operation in progress.
REQ-013 illegal  output  1  accepted request had an undecodable funct.

Function
REQ-014 Accept = in_valid & in_ready, sampled at rising clk; in_ready SHALL equal ~busy (combinational from state only, never from in_valid).
REQ-015 Decode: alu_op 01 -> ADD 0011; 10 -> SUB 0100; 11 -> OR 0001 (immediate logic, new class); 00 -> R-type by funct.
REQ-016 R-type table: 100000 ADD 0011; 100010 SUB 0100; 100100 AND 0000; 100101 OR 0001; 101010 SLT 0101; 000000 SLL 1001; 000010 SRL 1100; 011000 MULT 0110; 011010 DIV 0111.
REQ-017 Any other R-type funct SHALL decode to ctrl 0000 with illegal=1.
REQ-018 States: IDLE, ISSUE, BUSY; IDLE->ISSUE on accept of single-cycle op; IDLE->BUSY on accept of MULT/DIV; ISSUE->IDLE or ISSUE (next accept) or BUSY.
REQ-019 Single-cycle op accepted at edge N: ctrl, illegal valid and out_valid=1 for exactly cycle N+1 (latency 1).
REQ-020 Back-to-back single-cycle accepts SHALL sustain one result per cycle (out_valid held high).
REQ-021 MULT/DIV accepted at edge N: busy=1 cycles N+1..N+LAT; ctrl held constant throughout; out_valid=1 only in cycle N+LAT.
REQ-022 Down-counter width ceil(log2(max(MULT_LAT,DIV_LAT))); loaded LAT-1 on accept, decremented each BUSY cycle, exit at 0; no wrap.
REQ-023 BUSY -> IDLE after last busy cycle; first new accept possible at edge N+LAT+1.
REQ-024 in_valid/alu_op/funct changes while busy SHALL be ignored.
REQ-025 When out_valid=0, ctrl SHALL hold last value and illegal SHALL be 0.

Reset
REQ-026 rst_n low: state IDLE, counter 0, ctrl 0, out_valid 0, busy 0, illegal 0, in_ready 1, immediately and asynchronously.
REQ-027 Reset during BUSY SHALL discard the pending operation; no out_valid pulse is produced for it.
REQ-028 Deassertion is synchronous to clk; first accept possible at first rising edge with rst_n high.

Configuration
REQ-029 Macro ALU_CTRL_SEQ_DIV_EN defined: funct 011010 decodes as DIV per REQ-016/REQ-021.
REQ-030 Macro undefined: funct 011010 treated as illegal (ctrl 0000, illegal=1, single-cycle); DIV_LAT unused, counter sized by MULT_LAT.

Verification
REQ-031 Reset, then alu_op=00 funct=100010 accepted -> next cycle ctrl=0100, out_valid=1, busy=0.
REQ-032 Accepts on 4 consecutive cycles: alu_op 01, 10, 11, 00/101010 -> ctrl 0011, 0100, 0001, 0101 on cycles +1..+4, out_valid continuous.
REQ-033 MULT_LAT=4, funct=011000 accepted at N -> busy N+1..N+4, in_ready=0, ctrl=0110, out_valid only at N+4; in_valid held high with 100000 accepted at N+5 -> ctrl 0011 at N+6.
REQ-034 funct=111111 under alu_op 00 -> ctrl 0000, illegal=1 one cycle; with macro undefined funct=011010 -> same response.
REQ-035 DIV_LAT=8 with macro defined, DIV accepted, rst_n pulsed low at 3rd busy cycle -> all outputs 0 immediately, in_ready=1, no out_valid afterwards.
